stack_ctrl: RTL and testbench
=============================

Name: stack_ctrl

Overview:
Stack-operation sequencer that sits directly upstream of the stack-pointer register. It accepts PUSH/POP/CALL/RET requests from the decode stage and drives the data-memory port. It computes spnext/sp_we for the SP register, returns popped data or return addresses, and flags overflow/underflow. The stack is empty-ascending from address 0, matching the SP reset value of 0.

Parameters:
DEPTH, 256, stack capacity in 32-bit words; SP limit = DEPTH*4 bytes.
AW, 32, address/data width (SP width).

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
req_valid  input  1  operation request
req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready
op  input  2  00 PUSH, 01 POP, 10 CALL, 11 RET
wdata  input  32  PUSH data
pc_plus4  input  32  CALL return address
spcurr  input  32  current SP from SP register
spnext  output  32  next SP value
sp_we  output  1  SP register write enable
mem_addr  output  32  data-memory byte address
mem_wdata  output  32  data-memory write data
mem_we  output  1  data-memory write strobe
mem_re  output  1  data-memory read strobe
mem_rdata  input  32  read data, valid the cycle after mem_re (synchronous memory)
rdata  output  32  POP result
rdata_valid  output  1  one-cycle pulse, POP result valid
pc_target  output  32  RET target
pc_load  output  1  one-cycle pulse, RET target valid
err_ovf  output  1  one-cycle pulse, PUSH/CALL rejected (stack full)
err_unf  output  1  one-cycle pulse, POP/RET rejected (stack empty)

Behaviour:
- States: IDLE, WRITE, READ, RWAIT, RESP, ERR.
- Reset (async, any state): state=IDLE; all outputs, latched op and latched data = 0. req_ready rises with the first cycle after reset deassertion. Reset mid-operation abandons the operation; mem_we/sp_we drop immediately.
- SP handling:
  - spcurr[1:0] is ignored; all addresses use spcurr with bits [1:0] = 00.
  - Arithmetic is modulo 2^32 but is never reached because of the range checks.
- IDLE, on accept: latch op, and latch wdata (PUSH) or pc_plus4 (CALL).
  - PUSH/CALL with spcurr >= DEPTH*4 -> ERR.
  - POP/RET with spcurr == 0 -> ERR.
  - Otherwise PUSH/CALL -> WRITE and POP/RET -> READ.
- WRITE (1 cycle):
  - mem_we=1, mem_addr=sp, mem_wdata=latched data.
  - sp_we=1, spnext=sp+4.
  - -> IDLE.
- READ (1 cycle):
  - mem_re=1, mem_addr=sp-4.
  - sp_we=1, spnext=sp-4.
  - -> RWAIT.
- RWAIT (1 cycle): capture mem_rdata into result register -> RESP.
- RESP (1 cycle):
  - POP: rdata=result, rdata_valid=1.
  - RET: pc_target=result, pc_load=1.
  - -> IDLE.
  - rdata/pc_target hold their value until the next POP/RET respectively.
- ERR (1 cycle): err_ovf or err_unf=1; no memory access; sp_we=0 -> IDLE.
- Strobe defaults: sp_we, mem_we, mem_re and all pulses are 0 outside the states above. spnext=spcurr when sp_we=0.
- Latency, accept cycle = T:
  - PUSH/CALL: write at T+1, ready at T+2.
  - POP/RET: read at T+1, result pulse at T+3, ready at T+4.
  - Error: pulse at T+1, ready at T+2.
- At most one operation in flight. req_valid held during a busy period is ignored until req_ready.
- op and wdata are only sampled at accept; changes afterwards have no effect.
- SP register update: because sp_we is asserted in WRITE/READ, the SP register holds the new value from the following cycle. A request accepted on the immediate return to IDLE sees the updated spcurr.

Test Plan:
- PUSH 0xDEADBEEF at sp=0 -> T+1: mem_we=1, mem_addr=0x0, mem_wdata=0xDEADBEEF, sp_we=1, spnext=0x4; req_ready high at T+2.
- POP after that PUSH (sp=4) -> T+1: mem_re=1, mem_addr=0x0, spnext=0x0; T+3: rdata_valid=1, rdata=0xDEADBEEF.
- POP at sp=0 -> T+1: err_unf=1; no mem_re and no sp_we; sp stays 0.
- DEPTH=4: four PUSHes (sp 0->0x10), then a fifth PUSH -> err_ovf=1, no mem_we, sp stays 0x10.
- CALL with pc_plus4=0x104 then RET -> write 0x104 at addr 0; RET gives pc_load=1 with pc_target=0x104, sp back to 0; rdata_valid stays 0.
- Reset pulled low during RWAIT of a POP -> all outputs 0 immediately; no rdata_valid pulse; sp_we=0; req_ready=1 on the first clock after release.

Source files
------------

// File: rtl/stack_ctrl.sv
// Stack-operation sequencer: PUSH/POP/CALL/RET against a synchronous data memory.
// Ports: req_* handshake, op/wdata/pc_plus4 in, SP (spcurr/spnext/sp_we), mem_*, results, error pulses.
module stack_ctrl #(
  parameter int DEPTH = 256,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    op,
  input  logic [AW-1:0] wdata,
  input  logic [AW-1:0] pc_plus4,
  input  logic [AW-1:0] spcurr,
  output logic [AW-1:0] spnext,
  output logic          sp_we,
  output logic [AW-1:0] mem_addr,
  output logic [AW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [AW-1:0] mem_rdata,
  output logic [AW-1:0] rdata,
  output logic          rdata_valid,
  output logic [AW-1:0] pc_target,
  output logic          pc_load,
  output logic          err_ovf,
  output logic          err_unf
);

  localparam logic [AW-1:0] LIMIT = AW'(DEPTH * 4);
  localparam logic [AW-1:0] WORD  = AW'(4);

  typedef enum logic [2:0] {
    IDLE, WRITE, READ, RWAIT, RESP, ERR
  } state_t;

  state_t        state;
  logic [1:0]    op_q;
  logic [AW-1:0] spn_q;
  logic [AW-1:0] sp;
  logic          accept;
  logic          sp_lo_unused;

  // Word-aligned view of the SP; low bits are ignored.
  assign sp           = {spcurr[AW-1:2], 2'b00};
  assign sp_lo_unused = ^spcurr[1:0];
  assign accept       = req_valid && req_ready;

  // Pass SP through unchanged unless this cycle writes it.
  assign spnext = !rst ? '0 : (sp_we ? spn_q : spcurr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      op_q        <= '0;
      spn_q       <= '0;
      req_ready   <= 1'b0;
      sp_we       <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      pc_target   <= '0;
      pc_load     <= 1'b0;
      err_ovf     <= 1'b0;
      err_unf     <= 1'b0;
    end else begin
      req_ready   <= 1'b0;
      sp_we       <= 1'b0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      rdata_valid <= 1'b0;
      pc_load     <= 1'b0;
      err_ovf     <= 1'b0;
      err_unf     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_q <= op;
            if (!op[0]) begin
              mem_wdata <= op[1] ? pc_plus4 : wdata;
              if (sp >= LIMIT) begin
                state   <= ERR;
                err_ovf <= 1'b1;
              end else begin
                state    <= WRITE;
                mem_we   <= 1'b1;
                mem_addr <= sp;
                sp_we    <= 1'b1;
                spn_q    <= sp + WORD;
              end
            end else begin
              if (sp == '0) begin
                state   <= ERR;
                err_unf <= 1'b1;
              end else begin
                state    <= READ;
                mem_re   <= 1'b1;
                mem_addr <= sp - WORD;
                sp_we    <= 1'b1;
                spn_q    <= sp - WORD;
              end
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        WRITE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        READ: begin
          state <= RWAIT;
        end
        RWAIT: begin
          // Memory data is valid now; present it during RESP.
          state <= RESP;
          if (!op_q[1]) begin
            rdata       <= mem_rdata;
            rdata_valid <= 1'b1;
          end else begin
            pc_target <= mem_rdata;
            pc_load   <= 1'b1;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        ERR: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed testbench for stack_ctrl (DEPTH=4) with SP register and memory models.
// Each task drives one scenario and checks outputs inline.
module tb_stack_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  op = 2'b00;
  logic [31:0] wdata = '0;
  logic [31:0] pc_plus4 = '0;
  logic [31:0] spcurr;
  logic [31:0] spnext;
  logic        sp_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata = '0;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic [31:0] pc_target;
  logic        pc_load;
  logic        err_ovf;
  logic        err_unf;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [0:15];
  logic [31:0] sp_reg;

  stack_ctrl #(.DEPTH(4), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .wdata(wdata), .pc_plus4(pc_plus4),
    .spcurr(spcurr), .spnext(spnext), .sp_we(sp_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .rdata(rdata), .rdata_valid(rdata_valid),
    .pc_target(pc_target), .pc_load(pc_load),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  assign spcurr = sp_reg;

  always @(posedge clk or negedge rst)
    if (!rst) sp_reg <= '0;
    else if (sp_we) sp_reg <= spnext;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[5:2]];
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Waits for ready, presents one request, returns 1ns into cycle T+1.
  task automatic issue(input logic [1:0] o, input logic [31:0] d,
                       input logic [31:0] pc);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL issue_ready got %b want 1", req_ready);
    end
    req_valid = 1'b1;
    op = o;
    wdata = d;
    pc_plus4 = pc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    op = ~o;
    wdata = 32'hBAD0BAD0;
    pc_plus4 = 32'hBAD1BAD1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #2;
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %b want 0", req_ready); end
    n_cmp++; if ({sp_we, mem_we, mem_re, rdata_valid, pc_load, err_ovf, err_unf} !== 7'b0) begin
      n_bad++; $display("FAIL rst_strobes got %b want 0", {sp_we, mem_we, mem_re, rdata_valid, pc_load, err_ovf, err_unf});
    end
    n_cmp++; if ({spnext, mem_addr, mem_wdata, rdata, pc_target} !== 160'b0) begin
      n_bad++; $display("FAIL rst_data got %h %h %h %h %h want 0", spnext, mem_addr, mem_wdata, rdata, pc_target);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_early got %b want 0", req_ready); end
    step();
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_rise got %b want 1", req_ready); end
  endtask

  task automatic test_push_pop;
    issue(2'b00, 32'hDEADBEEF, 32'h0);
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL push_we got %b want 1", mem_we); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL push_addr got %h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL push_wdata got %h want deadbeef", mem_wdata); end
    n_cmp++; if (sp_we !== 1'b1 || spnext !== 32'h4) begin n_bad++; $display("FAIL push_sp got %b %h want 1 4", sp_we, spnext); end
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL push_busy got %b want 0", req_ready); end
    step();
    n_cmp++; if (req_ready !== 1'b1 || sp_reg !== 32'h4 || mem_we !== 1'b0) begin
      n_bad++; $display("FAIL push_done got rdy=%b sp=%h we=%b want 1 4 0", req_ready, sp_reg, mem_we);
    end
    issue(2'b01, 32'h0, 32'h0);
    n_cmp++; if (mem_re !== 1'b1 || mem_addr !== 32'h0) begin n_bad++; $display("FAIL pop_rd got %b %h want 1 0", mem_re, mem_addr); end
    n_cmp++; if (sp_we !== 1'b1 || spnext !== 32'h0) begin n_bad++; $display("FAIL pop_sp got %b %h want 1 0", sp_we, spnext); end
    step();
    n_cmp++; if (rdata_valid !== 1'b0) begin n_bad++; $display("FAIL pop_early got %b want 0", rdata_valid); end
    step();
    n_cmp++; if (rdata_valid !== 1'b1 || rdata !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL pop_data got %b %h want 1 deadbeef", rdata_valid, rdata);
    end
    n_cmp++; if (pc_load !== 1'b0) begin n_bad++; $display("FAIL pop_pcload got %b want 0", pc_load); end
    step();
    n_cmp++; if (req_ready !== 1'b1 || rdata_valid !== 1'b0 || sp_reg !== 32'h0) begin
      n_bad++; $display("FAIL pop_done got rdy=%b v=%b sp=%h want 1 0 0", req_ready, rdata_valid, sp_reg);
    end
  endtask

  task automatic test_underflow;
    issue(2'b01, 32'h0, 32'h0);
    n_cmp++; if (err_unf !== 1'b1) begin n_bad++; $display("FAIL unf_pulse got %b want 1", err_unf); end
    n_cmp++; if (mem_re !== 1'b0 || sp_we !== 1'b0 || spnext !== 32'h0) begin
      n_bad++; $display("FAIL unf_side got re=%b we=%b nx=%h want 0 0 0", mem_re, sp_we, spnext);
    end
    step();
    n_cmp++; if (err_unf !== 1'b0 || req_ready !== 1'b1 || sp_reg !== 32'h0) begin
      n_bad++; $display("FAIL unf_done got e=%b rdy=%b sp=%h want 0 1 0", err_unf, req_ready, sp_reg);
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 4; i++) begin
      issue(2'b00, 32'(32'h11 * (i + 1)), 32'h0);
      n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 32'(i * 4)) begin
        n_bad++; $display("FAIL fill_%0d got we=%b a=%h want 1 %h", i, mem_we, mem_addr, 32'(i * 4));
      end
      step();
    end
    n_cmp++; if (sp_reg !== 32'h10) begin n_bad++; $display("FAIL fill_sp got %h want 10", sp_reg); end
    issue(2'b00, 32'h99, 32'h0);
    n_cmp++; if (err_ovf !== 1'b1 || err_unf !== 1'b0) begin n_bad++; $display("FAIL ovf_pulse got %b %b want 1 0", err_ovf, err_unf); end
    n_cmp++; if (mem_we !== 1'b0 || sp_we !== 1'b0) begin n_bad++; $display("FAIL ovf_side got %b %b want 0 0", mem_we, sp_we); end
    step();
    n_cmp++; if (sp_reg !== 32'h10 || err_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_done got %h %b want 10 0", sp_reg, err_ovf); end
    for (int i = 0; i < 4; i++) begin
      issue(2'b01, 32'h0, 32'h0);
      step();
      step();
      n_cmp++; if (rdata_valid !== 1'b1 || rdata !== 32'(32'h11 * (4 - i))) begin
        n_bad++; $display("FAIL drain_%0d got %b %h want 1 %h", i, rdata_valid, rdata, 32'(32'h11 * (4 - i)));
      end
      step();
    end
    n_cmp++; if (sp_reg !== 32'h0) begin n_bad++; $display("FAIL drain_sp got %h want 0", sp_reg); end
  endtask

  task automatic test_call_ret;
    issue(2'b10, 32'h5555AAAA, 32'h104);
    n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'h104) begin
      n_bad++; $display("FAIL call_wr got %b %h %h want 1 0 104", mem_we, mem_addr, mem_wdata);
    end
    step();
    issue(2'b11, 32'h0, 32'h0);
    n_cmp++; if (mem_re !== 1'b1 || mem_addr !== 32'h0 || spnext !== 32'h0) begin
      n_bad++; $display("FAIL ret_rd got %b %h %h want 1 0 0", mem_re, mem_addr, spnext);
    end
    step();
    step();
    n_cmp++; if (pc_load !== 1'b1 || pc_target !== 32'h104) begin
      n_bad++; $display("FAIL ret_pc got %b %h want 1 104", pc_load, pc_target);
    end
    n_cmp++; if (rdata_valid !== 1'b0 || rdata !== 32'h11) begin
      n_bad++; $display("FAIL ret_rdata got %b %h want 0 11", rdata_valid, rdata);
    end
    step();
    n_cmp++; if (pc_load !== 1'b0 || sp_reg !== 32'h0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL ret_done got %b %h %b want 0 0 1", pc_load, sp_reg, req_ready);
    end
  endtask

  task automatic test_reset_mid;
    issue(2'b00, 32'h55, 32'h0);
    step();
    issue(2'b01, 32'h0, 32'h0);
    step();
    rst = 1'b0;
    #1;
    n_cmp++; if ({req_ready, sp_we, mem_we, mem_re, rdata_valid, pc_load, err_ovf, err_unf} !== 8'b0) begin
      n_bad++; $display("FAIL mid_strobes got %b want 0", {req_ready, sp_we, mem_we, mem_re, rdata_valid, pc_load, err_ovf, err_unf});
    end
    n_cmp++; if ({spnext, mem_addr, rdata, pc_target} !== 128'b0) begin
      n_bad++; $display("FAIL mid_data got %h %h %h %h want 0", spnext, mem_addr, rdata, pc_target);
    end
    step();
    n_cmp++; if (rdata_valid !== 1'b0) begin n_bad++; $display("FAIL mid_novalid got %b want 0", rdata_valid); end
    @(negedge clk);
    rst = 1'b1;
    step();
    n_cmp++; if (req_ready !== 1'b1 || rdata_valid !== 1'b0 || sp_we !== 1'b0) begin
      n_bad++; $display("FAIL mid_release got %b %b %b want 1 0 0", req_ready, rdata_valid, sp_we);
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_underflow();
    test_overflow();
    test_call_ret();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
